// File: rtl/load_store_unit.sv
// Load/store unit: issues aligned accesses directly, splits misaligned H/W
// accesses into byte accesses when MISALIGN_SPLIT_EN is defined (otherwise they fault).
module load_store_unit #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [2:0]           reqFunct3,
  input  logic [ADDR_SIZE-1:0] reqAddr,
  input  logic [WORD_LEN-1:0]  reqWdata,
  output logic                 respValid,
  output logic [WORD_LEN-1:0]  respData,
  output logic                 respFault,
  output logic                 memWriteEnable,
  output logic [ADDR_SIZE-1:0] memAddr,
  output logic [2:0]           memUnitSize,
  output logic [WORD_LEN-1:0]  memWriteData,
  input  logic [WORD_LEN-1:0]  memReadData
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic [1:0]           state_q,  state_d;
  logic                 write_q,  write_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [ADDR_SIZE-1:0] addr_q,   addr_d;
  logic [WORD_LEN-1:0]  wdata_q,  wdata_d;
  logic                 fault_q,  fault_d;
  logic [WORD_LEN-1:0]  asm_q,    asm_d;
`ifdef MISALIGN_SPLIT_EN
  logic                 split_q,  split_d;
  logic [1:0]           cnt_q,    cnt_d;
  logic [1:0]           last_cnt;
`endif

  logic req_legal;
  logic req_misal;

  always_comb begin
    if (reqWrite) begin
      req_legal = (reqFunct3 == F_B) || (reqFunct3 == F_H) || (reqFunct3 == F_W);
    end else begin
      req_legal = (reqFunct3 == F_B) || (reqFunct3 == F_H) || (reqFunct3 == F_W) ||
                  (reqFunct3 == F_BU) || (reqFunct3 == F_HU);
    end
    req_misal = ((reqFunct3[1:0] == 2'b01) && reqAddr[0]) ||
                ((reqFunct3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00));
  end

`ifdef MISALIGN_SPLIT_EN
  assign last_cnt = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
`endif

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    asm_d    = asm_q;
`ifdef MISALIGN_SPLIT_EN
    split_d  = split_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          write_d  = reqWrite;
          funct3_d = reqFunct3;
          addr_d   = reqAddr;
          wdata_d  = reqWdata;
          asm_d    = '0;
`ifdef MISALIGN_SPLIT_EN
          fault_d  = !req_legal;
          split_d  = req_legal && req_misal;
          cnt_d    = '0;
`else
          fault_d  = !req_legal || req_misal;
`endif
          state_d  = fault_d ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
`ifdef MISALIGN_SPLIT_EN
        if (split_q) begin
          if (!write_q) begin
            asm_d[{cnt_q, 3'b000} +: 8] = memReadData[7:0];
          end
          if (cnt_q == last_cnt) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          if (!write_q) begin
            asm_d = memReadData;
          end
          state_d = S_DONE;
        end
`else
        if (!write_q) begin
          asm_d = memReadData;
        end
        state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port is driven purely from state so it idles the instant reset asserts.
  always_comb begin
    memWriteEnable = 1'b0;
    memAddr        = '0;
    memUnitSize    = '0;
    memWriteData   = '0;
    if (state_q == S_ACCESS) begin
      memWriteEnable = write_q;
`ifdef MISALIGN_SPLIT_EN
      if (split_q) begin
        memAddr      = addr_q + ADDR_SIZE'(cnt_q);
        memUnitSize  = write_q ? F_B : F_BU;
        memWriteData = write_q ? WORD_LEN'(wdata_q[{cnt_q, 3'b000} +: 8]) : '0;
      end else begin
        memAddr      = addr_q;
        memUnitSize  = funct3_q;
        memWriteData = write_q ? wdata_q : '0;
      end
`else
      memAddr      = addr_q;
      memUnitSize  = funct3_q;
      memWriteData = write_q ? wdata_q : '0;
`endif
    end
  end

  always_comb begin
    reqReady  = (state_q == S_IDLE);
    respValid = (state_q == S_DONE);
    respFault = (state_q == S_DONE) && fault_q;
    respData  = '0;
    if ((state_q == S_DONE) && !fault_q && !write_q) begin
      case (funct3_q)
        F_B:     respData = {{(WORD_LEN-8){asm_q[7]}}, asm_q[7:0]};
        F_H:     respData = {{(WORD_LEN-16){asm_q[15]}}, asm_q[15:0]};
        F_BU:    respData = {{(WORD_LEN-8){1'b0}}, asm_q[7:0]};
        F_HU:    respData = {{(WORD_LEN-16){1'b0}}, asm_q[15:0]};
        default: respData = asm_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      asm_q    <= '0;
`ifdef MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      asm_q    <= asm_d;
`ifdef MISALIGN_SPLIT_EN
      split_q  <= split_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the pipeline and drives the data memory's addr/unitSize/writeEnable/writeData port, which has a combinational read and a write on the clock edge.
- Aligned accesses are issued as one memory access.
- Misaligned halfword/word accesses are split into sequential byte accesses, and load bytes are reassembled and extended.
- Returns one response per request through a valid/ready handshake.

Parameters:
- ADDR_SIZE, 32, byte address width.
- WORD_LEN, 32, data width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- reqValid  input  1  request present
- reqReady  output  1  LSU can accept a request; high only in IDLE
- reqWrite  input  1  1 = store, 0 = load
- reqFunct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- reqAddr  input  ADDR_SIZE  byte address
- reqWdata  input  WORD_LEN  store data, right-aligned
- respValid  output  1  one-cycle response pulse
- respData  output  WORD_LEN  load result; 0 for stores and faults
- respFault  output  1  qualifies respValid; request rejected
- memWriteEnable  output  1  memory write strobe
- memAddr  output  ADDR_SIZE  memory byte address
- memUnitSize  output  3  memory access size (funct3 encoding)
- memWriteData  output  WORD_LEN  memory store data, right-aligned
- memReadData  input  WORD_LEN  memory read data, valid in the same cycle

Behaviour:
- Reset (rstn low, asynchronous):
  - state IDLE, reqReady=1.
  - respValid, respData, respFault, memWriteEnable, memAddr, memUnitSize, memWriteData all 0.
  - Byte counter and assembly register cleared.
- States:
  - IDLE: reqReady=1. On reqValid&&reqReady, capture write, funct3, addr and wdata, classify the request, then go to ACCESS, or to DONE if it faults.
  - ACCESS: drive the memory port from the captured registers.
    - Aligned: one cycle, memUnitSize = captured funct3, memAddr = addr.
    - Split: one cycle per byte k = 0..n-1 (n=2 for H/HU, n=4 for W). memAddr = addr+k modulo 2^ADDR_SIZE, memUnitSize=100 for loads and 000 for stores, memWriteData = wdata[8k+7:8k].
    - Load: sample memReadData at the end of each access cycle; byte k goes to assembly[8k+7:8k].
    - Store: memWriteEnable=1 for every access cycle.
    - After the last access, go to DONE.
  - DONE: respValid=1 for exactly one cycle, then IDLE.
    - respData is sign-extended (B, H) or zero-extended (BU, HU) from the assembled bytes, or the full word (W).
- Outside ACCESS: memWriteEnable=0; memAddr, memUnitSize and memWriteData are 0.
- Latency from the accept cycle T:
  - aligned response at T+2.
  - split halfword response at T+3; split word response at T+5.
  - fault response at T+1.
- Misaligned definition: H/HU with addr[0]=1; W with addr[1:0]!=0. Byte accesses are never misaligned.
- Illegal funct3 faults with no memory activity in every configuration:
  - load funct3 011, 110, 111.
  - store funct3 other than 000, 001, 010.
- Requests are never accepted outside IDLE. reqValid held high during ACCESS/DONE is accepted on the first IDLE cycle, which is the cycle after DONE.
- Split accesses crossing a word boundary or the top of the address space wrap modulo 2^ADDR_SIZE.
- Reset asserted mid-operation:
  - immediate return to IDLE with the memory port idle.
  - no response is issued.
  - bytes already written by a partial split store remain in memory.

Optional Feature:
- Macro MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into byte accesses as described above.
- Undefined:
  - misaligned requests fault at T+1 with respFault=1 and respData=0.
  - zero memory accesses are issued.
  - no split-counter logic is instantiated.

Test Plan:
- Preload for scenarios 1–4: word 0x100 = 0x8899AABB, word 0x104 = 0x11223344.
1. Aligned LW 0x100 accepted at T → one ACCESS cycle with memUnitSize=010 and memAddr=0x100; respValid at T+2 with respData=0x8899AABB and respFault=0.
2. LB 0x103 → respData=0xFFFFFF88. LBU 0x103 → 0x00000088. LHU 0x102 → 0x00008899.
3. LW 0x102:
   - with MISALIGN_SPLIT_EN: byte reads at 0x102..0x105, response at T+5 with respData=0x33448899.
   - without it: respFault=1 at T+1 and memAddr stays 0 throughout.
4. With MISALIGN_SPLIT_EN: SH 0x103 with wdata 0x0000CAFE → byte writes FE@0x103 then CA@0x104. Memory then holds word 0x100 = 0xFE99AABB and word 0x104 = 0x112233CA. A following LH 0x103 returns 0xFFFFCAFE.
5. Load with funct3 011 → respFault=1 at T+1, memWriteEnable never asserted. reqValid held high through a request → second request accepted only on the IDLE cycle after respValid.
6. With MISALIGN_SPLIT_EN: SW 0x101 with wdata 0xDEADBEEF, rstn asserted after 2 byte writes → memWriteEnable drops immediately, no respValid, reqReady=1, and memory bytes 0x101=0xEF and 0x102=0xBE are retained.
